// File: rtl/trap_sequencer.sv
// Trap entry sequencer: arbitrates exceptions/interrupts, writes EPC/CAUSE/TVAL/STATUS, then redirects fetch.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt entry when tvec[1:0] = 01.
module trap_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            exc_valid_i,
  input  logic [5:0]      exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic [11:0]     irq_pending_i,
  input  logic [11:0]     irq_enable_i,
  input  logic [1:0]      priv_i,
  input  logic [XLEN-1:0] status_i,
  input  logic [15:0]     medeleg_i,
  input  logic [11:0]     mideleg_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] stvec_i,
  output logic            csr_we_o,
  output logic [11:0]     csr_addr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  input  logic            csr_ready_i,
  output logic            trap_ack_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [1:0]      redirect_priv_o,
  output logic            busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_EPC, S_W_CAUSE, S_W_TVAL, S_W_STATUS, S_REDIRECT
  } state_t;

  // Interrupt bits in descending priority; rank 0 wins.
  localparam int IRQ_PRIO [6] = '{11, 3, 7, 9, 1, 5};

  state_t          state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] status_q, status_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            target_s_q, target_s_d;

  logic [11:0]     irq_active;
  logic [5:0]      irq_elig;
  logic [5:0]      irq_sdel;
  logic            m_ok, s_ok;
  logic            irq_hit, irq_to_s;
  logic [5:0]      irq_code;
  logic            exc_to_s;
  logic            cap_to_s;
  logic [5:0]      cap_code;
  logic [XLEN-1:0] cap_tvec, cap_base, cap_cause, cap_status, cap_pc;
  logic            unused_irq_bits;

  assign irq_active = irq_pending_i & irq_enable_i;
  assign m_ok = (priv_i != 2'd3) || status_i[3];
  assign s_ok = (priv_i == 2'd0) || ((priv_i == 2'd1) && status_i[1]);

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_irq
      assign irq_sdel[gi] = mideleg_i[IRQ_PRIO[gi]];
      assign irq_elig[gi] = irq_active[IRQ_PRIO[gi]] && (irq_sdel[gi] ? s_ok : m_ok);
    end
  endgenerate

  assign unused_irq_bits = ^{irq_active[10], irq_active[8], irq_active[6], irq_active[4],
                             irq_active[2], irq_active[0], mideleg_i[10], mideleg_i[8],
                             mideleg_i[6], mideleg_i[4], mideleg_i[2], mideleg_i[0]};

  always_comb begin
    irq_hit  = 1'b0;
    irq_to_s = 1'b0;
    irq_code = 6'd0;
    for (int i = 5; i >= 0; i--) begin
      if (irq_elig[i]) begin
        irq_hit  = 1'b1;
        irq_to_s = irq_sdel[i];
        irq_code = 6'(IRQ_PRIO[i]);
      end
    end
  end

  // medeleg only covers causes 0..15; higher causes always go to M.
  assign exc_to_s = (priv_i != 2'd3) && (exc_cause_i[5:4] == 2'b00) && medeleg_i[exc_cause_i[3:0]];

  always_comb begin
    cap_to_s   = exc_valid_i ? exc_to_s : irq_to_s;
    cap_code   = exc_valid_i ? exc_cause_i : irq_code;
    cap_tvec   = cap_to_s ? stvec_i : mtvec_i;
    cap_base   = {cap_tvec[XLEN-1:2], 2'b00};
    cap_cause  = '0;
    cap_cause[5:0]      = cap_code;
    cap_cause[XLEN-1]   = !exc_valid_i;
    cap_status = status_i;
    if (cap_to_s) begin
      cap_status[5] = status_i[1];
      cap_status[1] = 1'b0;
      cap_status[8] = priv_i[0];
    end else begin
      cap_status[7]     = status_i[3];
      cap_status[3]     = 1'b0;
      cap_status[12:11] = priv_i;
    end
    cap_pc = cap_base;
`ifdef TRAP_VECTORED_EN
    if (!exc_valid_i && (cap_tvec[1:0] == 2'b01)) begin
      cap_pc = cap_base + {{(XLEN-8){1'b0}}, cap_code, 2'b00};
    end
`endif
  end

`ifndef TRAP_VECTORED_EN
  logic unused_tvec_mode;
  assign unused_tvec_mode = ^cap_tvec[1:0];
`endif

  always_comb begin
    state_d    = state_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    tval_d     = tval_q;
    status_d   = status_q;
    pc_d       = pc_q;
    target_s_d = target_s_q;
    case (state_q)
      S_IDLE: begin
        if (exc_valid_i || irq_hit) begin
          state_d    = S_W_EPC;
          epc_d      = exc_pc_i;
          cause_d    = cap_cause;
          tval_d     = exc_valid_i ? exc_tval_i : '0;
          status_d   = cap_status;
          pc_d       = cap_pc;
          target_s_d = cap_to_s;
        end
      end
      S_W_EPC:    if (csr_ready_i) state_d = S_W_CAUSE;
      S_W_CAUSE:  if (csr_ready_i) state_d = S_W_TVAL;
      S_W_TVAL:   if (csr_ready_i) state_d = S_W_STATUS;
      S_W_STATUS: if (csr_ready_i) state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      epc_q      <= '0;
      cause_q    <= '0;
      tval_q     <= '0;
      status_q   <= '0;
      pc_q       <= '0;
      target_s_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      tval_q     <= tval_d;
      status_q   <= status_d;
      pc_q       <= pc_d;
      target_s_q <= target_s_d;
    end
  end

  // S-mode CSR addresses sit 0x200 below their M-mode counterparts.
  always_comb begin
    csr_we_o    = 1'b0;
    csr_addr_o  = 12'h000;
    csr_wdata_o = '0;
    case (state_q)
      S_W_EPC: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = target_s_q ? 12'h141 : 12'h341;
        csr_wdata_o = epc_q;
      end
      S_W_CAUSE: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = target_s_q ? 12'h142 : 12'h342;
        csr_wdata_o = cause_q;
      end
      S_W_TVAL: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = target_s_q ? 12'h143 : 12'h343;
        csr_wdata_o = tval_q;
      end
      S_W_STATUS: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = target_s_q ? 12'h100 : 12'h300;
        csr_wdata_o = status_q;
      end
      default: ;
    endcase
  end

  assign redirect_valid_o = (state_q == S_REDIRECT);
  assign trap_ack_o       = (state_q == S_REDIRECT);
  assign redirect_pc_o    = pc_q;
  assign redirect_priv_o  = target_s_q ? 2'd1 : 2'd3;
  assign busy_o           = (state_q != S_IDLE);

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 64, CSR/PC datapath width.
REQ-002 SHALL have ports, clock and reset first:
- clock_i  in  1  sole clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- exc_valid_i  in  1  synchronous exception request from core; held until trap_ack_o.
- exc_cause_i  in  6  exception code.
- exc_pc_i  in  XLEN  faulting PC.
- exc_tval_i  in  XLEN  exception trap value.
- irq_pending_i  in  12  mip bits 11:0.
- irq_enable_i  in  12  mie bits 11:0.
- priv_i  in  2  current privilege (3=M, 1=S, 0=U).
- status_i  in  XLEN  current mstatus value.
- medeleg_i  in  16  exception delegation.
- mideleg_i  in  12  interrupt delegation.
- mtvec_i / stvec_i  in  XLEN  trap vectors.
- csr_we_o  out  1  CSR write request.
- csr_addr_o  out  12  CSR write address.
- csr_wdata_o  out  XLEN  CSR write data.
- csr_ready_i  in  1  CSR file accepts the write this cycle.
- trap_ack_o  out  1  one-cycle pulse: trap committed.
- redirect_valid_o  out  1  one-cycle pulse: fetch redirect.
- redirect_pc_o  out  XLEN  trap handler PC.
- redirect_priv_o  out  2  privilege after the trap.
- busy_o  out  1  high in any state other than IDLE.

Function
REQ-003 SHALL implement FSM IDLE -> W_EPC -> W_CAUSE -> W_TVAL -> W_STATUS -> REDIRECT -> IDLE.
REQ-004 In IDLE, SHALL arbitrate each cycle; on a winner, latch cause, PC, tval, target and priv_i, then go to W_EPC.
REQ-005 Exception SHALL win over any interrupt.
REQ-006 Interrupt priority SHALL be 11 > 3 > 7 > 9 > 1 > 5; other bits ignored.
REQ-007 An exception SHALL target S iff priv_i != 3 and medeleg_i[cause] = 1; otherwise it targets M.
REQ-008 An interrupt SHALL target S iff mideleg_i[bit] = 1; otherwise it targets M.
REQ-009 An interrupt SHALL be eligible only if pending & enable, and:
- M target: priv_i < 3, or status_i[3] = 1;
- S target: priv_i < 1, or (priv_i = 1 and status_i[1] = 1);
- S target is never eligible when priv_i = 3.
REQ-010 W_* states SHALL hold csr_we_o=1 with stable addr/data until csr_ready_i=1, then advance; csr_we_o=0 elsewhere.
REQ-011 Addresses SHALL be EPC/CAUSE/TVAL/STATUS = 0x341/0x342/0x343/0x300 for M and 0x141/0x142/0x143/0x100 for S.
REQ-012 Write data SHALL be:
- EPC: latched PC.
- CAUSE: interrupt flag in bit XLEN-1, code in low bits.
- TVAL: exc_tval, or 0 for interrupts.
- STATUS for M: latched status with bit7 <= bit3, bit3 <= 0, bits12:11 <= priv.
- STATUS for S: bit5 <= bit1, bit1 <= 0, bit8 <= priv[0].
REQ-013 REDIRECT SHALL pulse redirect_valid_o and trap_ack_o together for one cycle, with redirect_priv_o = target (3 or 1).
REQ-014 With csr_ready_i tied high, redirect SHALL occur exactly 5 cycles after the winning IDLE cycle.
REQ-015 Requests arriving while busy_o=1 SHALL be ignored; a held exc_valid_i is re-arbitrated in the first IDLE cycle after REDIRECT.
REQ-016 Input changes after capture SHALL NOT affect the sequence in progress.

Reset
REQ-017 reset_i SHALL force IDLE and drive every output to 0, except redirect_priv_o = 3.
REQ-018 Reset mid-sequence SHALL abort with no further CSR write, redirect or ack.

Configuration
REQ-019 With TRAP_VECTORED_EN defined, an interrupt with tvec[1:0] = 01 SHALL use redirect_pc = {tvec[XLEN-1:2], 00} + 4*code.
REQ-020 With TRAP_VECTORED_EN defined, exceptions and the tvec[1:0] = 00 case SHALL use base = {tvec[XLEN-1:2], 00}.
REQ-021 Without TRAP_VECTORED_EN, redirect_pc SHALL always be base and tvec mode bits SHALL be ignored.

Verification
REQ-022 priv=0, exc cause 2, pc=0x1000, medeleg=0, mtvec=0x8000 -> writes 0x341=0x1000, 0x342=2, 0x343=tval, then 0x300 with MPP=0; redirect 0x8000, priv 3 at cycle 5.
REQ-023 priv=0, medeleg[8]=1, exc cause 8 -> addresses 0x141..0x100, SPP=0, redirect stvec, priv 1.
REQ-024 pending=enable=0x888, MIE=1, priv=3 -> cause = (1<<63)|11; with macro and mtvec=0x8001, redirect 0x802C; without macro, redirect 0x8000.
REQ-025 csr_ready_i low 3 cycles during W_CAUSE -> addr/data stable, redirect delayed by exactly 3 cycles.
REQ-026 reset_i asserted in W_TVAL -> no STATUS write, no redirect, outputs at reset values next cycle.
